// File: rtl/conv_in_buffer_if.sv
// conv_in_buffer_if: loader write stream plus conv_layer read port for the
// input feature-map buffer. The buffer is the slave; loader and conv_layer
// together form the master side.
interface conv_in_buffer_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 5
);
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              fin_rd;
   logic              in0_rden;
   logic              in1_rden;
   logic              in2_rden;
   logic              in3_rden;
   logic [ADDR_W-1:0] in_addr;
   logic              start_rd;
   logic [DATA_W-1:0] in0_q;
   logic [DATA_W-1:0] in1_q;
   logic [DATA_W-1:0] in2_q;
   logic [DATA_W-1:0] in3_q;
   logic              busy;

   modport master (
      output wr_valid, wr_data, fin_rd,
      output in0_rden, in1_rden, in2_rden, in3_rden, in_addr,
      input  wr_ready, start_rd, busy,
      input  in0_q, in1_q, in2_q, in3_q
   );

   modport slave (
      input  wr_valid, wr_data, fin_rd,
      input  in0_rden, in1_rden, in2_rden, in3_rden, in_addr,
      output wr_ready, start_rd, busy,
      output in0_q, in1_q, in2_q, in3_q
   );
endinterface

// File: rtl/conv_in_buffer.sv
// conv_in_buffer: four-bank input feature-map buffer. Loads 4*DEPTH words
// bank-interleaved from the loader, pulses start_rd, then serves per-bank
// reads with 1-cycle latency until fin_rd.
// Optional: CONV_IN_BUFFER_ZPAD_EN makes reads with in_addr >= DEPTH return
// zero (border padding); otherwise such reads clamp to address DEPTH-1.
module conv_in_buffer #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 28
) (
   input logic           clk,
   input logic           RESET,
   conv_in_buffer_if.slave bus
);
   localparam int CNT_W = $clog2(4 * DEPTH);
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(4 * DEPTH - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_READY = 2'd1,
      S_SERVE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_wr_ready;
   logic               r_start_rd;
   logic               r_busy;
   logic [DATA_W-1:0]  r_q [4];
   logic [DATA_W-1:0]  r_bank [4][DEPTH];

   logic               w_wr_fire;
   logic               w_last;
   logic [ADDR_W-1:0]  w_wr_addr;
   logic [3:0]         w_rden;
   logic               w_oob;
   logic [ADDR_W-1:0]  w_rd_idx;
   logic [DATA_W-1:0]  w_rd_data [4];

   assign w_wr_fire = (r_state == S_LOAD) && bus.wr_valid && r_wr_ready && !RESET;
   assign w_last    = (r_cnt == LAST_K);
   assign w_wr_addr = ADDR_W'(r_cnt >> 2);
   assign w_rden    = {bus.in3_rden, bus.in2_rden, bus.in1_rden, bus.in0_rden};

   // Read-side address decode: clamp (or flag for zero padding) out-of-range addresses.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_oob    = ({1'b0, bus.in_addr} >= DEPTH_L);
      w_rd_idx = w_oob ? ADDR_W'(DEPTH - 1) : bus.in_addr;
      for (int b = 0; b < 4; b++) begin
         w_rd_data[b] = r_bank[b][w_rd_idx];
`ifdef CONV_IN_BUFFER_ZPAD_EN
         if (w_oob) w_rd_data[b] = '0;
`else
`endif
      end
   end

   // Bank write: word k lands in bank k[1:0] at address k>>2.
   // NOTE: the storage array has no reset; its contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_bank[r_cnt[1:0]][w_wr_addr] <= bus.wr_data;
   end

   // Control FSM with registered handshake outputs and registered read data.
   always_ff @(posedge clk) begin
      if (RESET) begin
         r_state    <= S_LOAD;
         r_cnt      <= '0;
         r_wr_ready <= 1'b1;
         r_start_rd <= 1'b0;
         r_busy     <= 1'b0;
         for (int b = 0; b < 4; b++) r_q[b] <= '0;
      end else begin
         r_start_rd <= 1'b0;
         case (r_state)
            S_LOAD: begin
               if (w_wr_fire) begin
                  if (w_last) begin
                     r_cnt      <= '0;
                     r_state    <= S_READY;
                     r_wr_ready <= 1'b0;
                     r_start_rd <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_READY: begin
               r_state <= S_SERVE;
               r_busy  <= 1'b1;
            end
            S_SERVE: begin
               for (int b = 0; b < 4; b++) begin
                  if (w_rden[b]) r_q[b] <= w_rd_data[b];
               end
               if (bus.fin_rd) begin
                  r_state    <= S_LOAD;
                  r_busy     <= 1'b0;
                  r_wr_ready <= 1'b1;
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign bus.wr_ready = r_wr_ready;
   assign bus.start_rd = r_start_rd;
   assign bus.busy     = r_busy;
   assign bus.in0_q    = r_q[0];
   assign bus.in1_q    = r_q[1];
   assign bus.in2_q    = r_q[2];
   assign bus.in3_q    = r_q[3];
endmodule

// File: tb/tb_conv_in_buffer.sv
// tb_conv_in_buffer: directed test of load, start pulse, read latency,
// parallel reads, out-of-range reads, handoff and reset abort.
module tb_conv_in_buffer;
   localparam int DATA_W = 24;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 28;
   localparam int NWORDS = 4 * DEPTH;

   logic clk = 1'b0;
   logic RESET;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   conv_in_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   conv_in_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.fin_rd   = 1'b0;
      bus.in0_rden = 1'b0;
      bus.in1_rden = 1'b0;
      bus.in2_rden = 1'b0;
      bus.in3_rden = 1'b0;
      bus.in_addr  = '0;
   endtask

   // Stream NWORDS words of value base+k; start_rd must only rise after the last one.
   task automatic load_full(input int base, input string tag);
      int early = 0;
      for (int k = 0; k < NWORDS; k++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = DATA_W'(base + k);
         tick();
         if (k < NWORDS - 1 && (bus.start_rd !== 1'b0 || bus.wr_ready !== 1'b1)) early++;
      end
      bus.wr_valid = 1'b0;
      cmp({tag, " no early start"}, 32'(early), 32'd0);
      cmp({tag, " start_rd pulse"}, 32'(bus.start_rd), 32'd1);
      cmp({tag, " wr_ready low"},   32'(bus.wr_ready), 32'd0);
      tick();
      cmp({tag, " start_rd cleared"}, 32'(bus.start_rd), 32'd0);
      cmp({tag, " busy in serve"},    32'(bus.busy),     32'd1);
      cmp({tag, " wr_ready serve"},   32'(bus.wr_ready), 32'd0);
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b1;
      tick();
      tick();
      cmp("reset wr_ready", 32'(bus.wr_ready), 32'd1);
      cmp("reset start_rd", 32'(bus.start_rd), 32'd0);
      cmp("reset busy",     32'(bus.busy),     32'd0);
      cmp("reset q0", 32'(bus.in0_q), 32'd0);
      cmp("reset q1", 32'(bus.in1_q), 32'd0);
      cmp("reset q2", 32'(bus.in2_q), 32'd0);
      cmp("reset q3", 32'(bus.in3_q), 32'd0);
      RESET = 1'b0;
      tick();
   endtask

   task automatic test_full_load();
      load_full(0, "load1");
   endtask

   task automatic test_read_latency();
      bus.in2_rden = 1'b1;
      bus.in_addr  = 5'd5;
      tick();
      cmp("latency q2 addr5", 32'(bus.in2_q), 32'd22);
      bus.in2_rden = 1'b0;
      bus.in_addr  = 5'd7;
      tick();
      cmp("hold q2 no rden", 32'(bus.in2_q), 32'd22);
   endtask

   task automatic test_parallel();
      bus.in0_rden = 1'b1;
      bus.in1_rden = 1'b1;
      bus.in2_rden = 1'b1;
      bus.in3_rden = 1'b1;
      bus.in_addr  = 5'd27;
      tick();
      idle_inputs();
      cmp("parallel q0", 32'(bus.in0_q), 32'd108);
      cmp("parallel q1", 32'(bus.in1_q), 32'd109);
      cmp("parallel q2", 32'(bus.in2_q), 32'd110);
      cmp("parallel q3", 32'(bus.in3_q), 32'd111);
   endtask

   task automatic test_out_of_range();
      // Preload bank0 q with a non-zero, non-108 value so both outcomes are visible.
      bus.in0_rden = 1'b1;
      bus.in_addr  = 5'd3;
      tick();
      cmp("preload q0 addr3", 32'(bus.in0_q), 32'd12);
      bus.in_addr  = 5'd30;
      tick();
      idle_inputs();
`ifdef CONV_IN_BUFFER_ZPAD_EN
      cmp("oob q0 addr30", 32'(bus.in0_q), 32'd0);
`else
      cmp("oob q0 addr30", 32'(bus.in0_q), 32'd108);
`endif
      cmp("oob q1 untouched", 32'(bus.in1_q), 32'd109);
   endtask

   task automatic test_handoff();
      // Read issued together with fin_rd still completes.
      bus.fin_rd   = 1'b1;
      bus.in0_rden = 1'b1;
      bus.in_addr  = 5'd1;
      tick();
      idle_inputs();
      cmp("fin read q0", 32'(bus.in0_q), 32'd4);
      cmp("fin wr_ready", 32'(bus.wr_ready), 32'd1);
      cmp("fin busy",     32'(bus.busy),     32'd0);
      // rden in LOAD is ignored.
      bus.in0_rden = 1'b1;
      bus.in_addr  = 5'd0;
      tick();
      bus.in0_rden = 1'b0;
      cmp("load rden ignored", 32'(bus.in0_q), 32'd4);
      load_full(1000, "load2");
      bus.in1_rden = 1'b1;
      bus.in_addr  = 5'd0;
      tick();
      idle_inputs();
      cmp("reload q1 addr0", 32'(bus.in1_q), 32'd1001);
   endtask

   task automatic test_abort();
      bus.fin_rd = 1'b1;
      tick();
      bus.fin_rd = 1'b0;
      for (int k = 0; k < 50; k++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = DATA_W'(5000 + k);
         tick();
      end
      bus.wr_valid = 1'b0;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      cmp("abort q1 cleared", 32'(bus.in1_q), 32'd0);
      cmp("abort wr_ready",   32'(bus.wr_ready), 32'd1);
      load_full(2000, "load3");
      bus.in0_rden = 1'b1;
      bus.in3_rden = 1'b1;
      bus.in_addr  = 5'd0;
      tick();
      cmp("abort q0 addr0", 32'(bus.in0_q), 32'd2000);
      cmp("abort q3 addr0", 32'(bus.in3_q), 32'd2003);
      bus.in_addr  = 5'd27;
      tick();
      idle_inputs();
      cmp("abort q3 addr27", 32'(bus.in3_q), 32'd2111);
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_read_latency();
      test_parallel();
      test_out_of_range();
      test_handoff();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_in_buffer.md
Name: conv_in_buffer

Overview:
- Input-side feature-map buffer that serves `conv_layer`'s read port; it is the responder to `conv_layer`'s `in*_rden`/`in_addr` requests.
- Accepts a word stream from the upstream loader and stores it across four 24-bit banks.
- Signals `start_rd` once all four banks are full, then answers bank reads with 1-cycle latency until `conv_layer` pulses `fin_rd`.
- Sits between the host/loader and `conv1` in `CNN_test`.

Parameters:
- DATA_W, 24, width of each bank word and of `wr_data`/`in*_q`.
- ADDR_W, 5, read/write address width per bank.
- DEPTH, 28, valid words per bank (1..2^ADDR_W); one full load = 4*DEPTH words.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- wr_valid  input  1  loader word valid.
- wr_data  input  DATA_W  loader word.
- wr_ready  output  1  buffer accepts a word this cycle.
- fin_rd  input  1  `conv_layer` finished reading; 1-cycle pulse.
- in0_rden .. in3_rden  input  1 each  per-bank read enable.
- in_addr  input  ADDR_W  read address, shared by all banks.
- start_rd  output  1  1-cycle pulse: buffer full, reads may begin.
- in0_q .. in3_q  output  DATA_W each  registered bank read data.
- busy  output  1  high in SERVE state.

Behaviour:
- Reset (RESET=1 at a clk edge) forces:
  - state=LOAD, wr_ready=1, start_rd=0, busy=0
  - in0_q..in3_q=0, write counter=0
  - memory contents are not cleared.
- Reset mid-load or mid-serve aborts the operation; the next load starts at word 0.
- FSM states: LOAD, READY, SERVE.
- LOAD:
  - wr_ready=1; a word is accepted when wr_valid && wr_ready.
  - Word index k (0..4*DEPTH-1) is written to bank k%4, address k/4 (bank-interleaved: k=0→bank0 addr0, k=1→bank1 addr0, …, k=4→bank0 addr1).
  - Write counter increments per accepted word.
  - On acceptance of word 4*DEPTH-1: next state READY, counter resets to 0, wr_ready drops to 0 the next cycle.
- READY:
  - Lasts exactly one cycle; start_rd=1 during it, then goes to SERVE.
  - wr_ready=0. rden inputs are ignored.
- SERVE:
  - busy=1, wr_ready=0.
  - For each bank b: if in{b}_rden=1 in cycle N, in{b}_q in cycle N+1 = bank b word at in_addr (latency 1).
  - If in{b}_rden=0, in{b}_q holds its previous value.
  - Banks are independent; any combination of rden may be high in the same cycle.
- fin_rd:
  - In SERVE: next state is LOAD. A read requested in that same cycle still completes, with q updated in cycle N+1.
  - In LOAD or READY: ignored.
- Read addresses with in_addr >= DEPTH: see Optional Feature.
- wr_valid outside LOAD is ignored and no data is written.
- rden outside SERVE: q holds.
- Arithmetic: the counter is wide enough for 4*DEPTH; bank select = counter[1:0], address = counter>>2. There is no data arithmetic.

Optional Feature:
- Macro: CONV_IN_BUFFER_ZPAD_EN.
- Defined: a read with in_addr >= DEPTH returns all-zero data (zero padding for the conv border).
- Not defined: the address is clamped, so in_addr >= DEPTH returns the bank's word at address DEPTH-1.
- In both cases, in_addr < DEPTH behaves identically.

Test Plan:
- Reset state: after reset → wr_ready=1, start_rd=0, busy=0, all in*_q=0.
- Full load: stream 112 words with value k, wr_valid held high, DEPTH=28 → start_rd pulses exactly 1 cycle, the cycle after word 111 is accepted; busy=1 the cycle after that; wr_ready=0.
- Read latency: in SERVE, in2_rden=1 with in_addr=5 in cycle N → in2_q=22 (k=5*4+2) in cycle N+1. In N+1 drop rden and set in_addr=7 → in2_q stays 22.
- Parallel reads: all rden=1, in_addr=27 → in0_q..in3_q = 108, 109, 110, 111 one cycle later.
- Out-of-range read: in_addr=30 on bank0 → q=0 with CONV_IN_BUFFER_ZPAD_EN defined; q=108 without it.
- Handoff and abort:
  - fin_rd pulse → LOAD next cycle, wr_ready=1, busy=0.
  - Second load of 112 words with value k+1000 → in1_q at addr 0 reads 1001.
  - Assert RESET after 50 words → counter restarts; 112 further words are required before start_rd.
